// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings and the
// bit layout of the latch control bundle, plus the fixed control patterns.
package pipe_stall_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_LOAD_USE  = 3'd1,
        ST_DMEM_WAIT = 3'd2,
        ST_IMEM_WAIT = 3'd3,
        ST_FLUSH     = 3'd4
    } state_e;

    localparam int CTL_W         = 8;
    localparam int CTL_PC_EN     = 7;
    localparam int CTL_IFID_EN   = 6;
    localparam int CTL_IDEX_EN   = 5;
    localparam int CTL_EXMEM_EN  = 4;
    localparam int CTL_MEMWB_EN  = 3;
    localparam int CTL_IFID_BUB  = 2;
    localparam int CTL_IDEX_BUB  = 1;
    localparam int CTL_MEMWB_BUB = 0;

    typedef logic [CTL_W-1:0] ctl_t;

    localparam ctl_t CTL_ALL_EN = ctl_t'((1 << CTL_PC_EN) | (1 << CTL_IFID_EN) |
                                         (1 << CTL_IDEX_EN) | (1 << CTL_EXMEM_EN) |
                                         (1 << CTL_MEMWB_EN));
    // Everything frozen except MEM/WB, which drains the stalled access as a NOP.
    localparam ctl_t CTL_FREEZE  = ctl_t'((1 << CTL_MEMWB_EN) | (1 << CTL_MEMWB_BUB));
    localparam ctl_t CTL_BRANCH  = CTL_ALL_EN | ctl_t'((1 << CTL_IFID_BUB) | (1 << CTL_IDEX_BUB));
    localparam ctl_t CTL_LDUSE   = ctl_t'((1 << CTL_IDEX_EN) | (1 << CTL_EXMEM_EN) |
                                          (1 << CTL_MEMWB_EN) | (1 << CTL_IDEX_BUB));
    localparam ctl_t CTL_IFSTALL = (CTL_ALL_EN & ~ctl_t'(1 << CTL_PC_EN)) | ctl_t'(1 << CTL_IFID_BUB);
    localparam ctl_t CTL_RESET   = (CTL_ALL_EN & ~ctl_t'(1 << CTL_PC_EN)) |
                                   ctl_t'((1 << CTL_IFID_BUB) | (1 << CTL_IDEX_BUB) |
                                          (1 << CTL_MEMWB_BUB));

    function automatic logic is_wait(input state_e s);
        return (s == ST_DMEM_WAIT) || (s == ST_IMEM_WAIT);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-source inputs and latch control outputs of the pipeline sequencer.
// master = pipeline/hazard side driving events, slave = the sequencer.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             imem_stall;
    logic             imem_done;
    logic             dmem_stall;
    logic             dmem_done;
    logic             branch_taken;
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_reads_rs;
    logic             id_reads_rt;
    logic [2:0]       idex_wreg;
    logic             idex_regwrite;
    logic             idex_memtoreg;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_bubble;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic             err_timeout;

    modport master (
        output imem_stall, imem_done, dmem_stall, dmem_done, branch_taken,
               id_rs, id_rt, id_reads_rs, id_reads_rt,
               idex_wreg, idex_regwrite, idex_memtoreg,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_bubble, idex_bubble, memwb_bubble,
               state, stall_cycles, err_timeout
    );

    modport slave (
        input  imem_stall, imem_done, dmem_stall, dmem_done, branch_taken,
               id_rs, id_rt, id_reads_rs, id_reads_rt,
               idex_wreg, idex_regwrite, idex_memtoreg,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_bubble, idex_bubble, memwb_bubble,
               state, stall_cycles, err_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl_hazard_cmp.sv
// Load-use detector: the load in ID/EX targets a register the ID instruction reads.
// Purely combinational, zero latency, no flow control.
module pipe_stall_ctrl_hazard_cmp (
    input  logic [2:0] i_id_rs,
    input  logic [2:0] i_id_rt,
    input  logic       i_id_reads_rs,
    input  logic       i_id_reads_rt,
    input  logic [2:0] i_idex_wreg,
    input  logic       i_idex_regwrite,
    input  logic       i_idex_memtoreg,
    output logic       o_load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit   = i_id_reads_rs && (i_id_rs == i_idex_wreg);
    assign w_rt_hit   = i_id_reads_rt && (i_id_rt == i_idex_wreg);
    assign o_load_use = i_idex_memtoreg && i_idex_regwrite && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: Mealy control of PC and latch enables/bubbles from stall sources.
// Zero-latency outputs from registered state; memory waits time out into a sticky error.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e             r_state;
    state_e             w_state_nxt;
    ctl_t               w_ctl;
    logic               w_load_use;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_inc;
    logic               r_err;
    logic [CNT_W-1:0]   r_stall_cnt;

    pipe_stall_ctrl_hazard_cmp u_hazard_cmp (
        .i_id_rs         (bus.id_rs),
        .i_id_rt         (bus.id_rt),
        .i_id_reads_rs   (bus.id_reads_rs),
        .i_id_reads_rt   (bus.id_reads_rt),
        .i_idex_wreg     (bus.idex_wreg),
        .i_idex_regwrite (bus.idex_regwrite),
        .i_idex_memtoreg (bus.idex_memtoreg),
        .o_load_use      (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN, ST_LOAD_USE, ST_FLUSH: begin
                if (bus.dmem_stall)                                  w_state_nxt = ST_DMEM_WAIT;
                else if (bus.branch_taken)                           w_state_nxt = ST_FLUSH;
                else if (w_load_use && (r_state != ST_LOAD_USE))     w_state_nxt = ST_LOAD_USE;
                else if (bus.imem_stall)                             w_state_nxt = ST_IMEM_WAIT;
                else                                                 w_state_nxt = ST_RUN;
            end
            ST_DMEM_WAIT: begin
                if (bus.dmem_done) w_state_nxt = ST_RUN;
            end
            ST_IMEM_WAIT: begin
                if (bus.imem_done)         w_state_nxt = bus.branch_taken ? ST_FLUSH : ST_RUN;
                else if (bus.branch_taken) w_state_nxt = ST_IMEM_WAIT;
                else if (bus.dmem_stall)   w_state_nxt = ST_DMEM_WAIT;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_ctl = CTL_ALL_EN;
        if (!rst) begin
            w_ctl = CTL_RESET;
        end else begin
            case (r_state)
                ST_RUN, ST_LOAD_USE, ST_FLUSH: begin
                    if (bus.dmem_stall)                              w_ctl = CTL_FREEZE;
                    else if (bus.branch_taken)                       w_ctl = CTL_BRANCH;
                    else if (w_load_use && (r_state != ST_LOAD_USE)) w_ctl = CTL_LDUSE;
                    else if (bus.imem_stall)                         w_ctl = CTL_IFSTALL;
                    else                                             w_ctl = CTL_ALL_EN;
                    // The fetch issued during the branch cycle is wrong-path.
                    if (r_state == ST_FLUSH) w_ctl[CTL_IFID_BUB] = 1'b1;
                end
                ST_DMEM_WAIT: begin
                    w_ctl = bus.dmem_done ? CTL_ALL_EN : CTL_FREEZE;
                end
                ST_IMEM_WAIT: begin
                    if (bus.imem_done)         w_ctl = bus.branch_taken ? CTL_BRANCH : CTL_ALL_EN;
                    else if (bus.branch_taken) w_ctl = CTL_FREEZE;
                    else if (bus.dmem_stall)   w_ctl = CTL_FREEZE;
                    else                       w_ctl = CTL_IFSTALL;
                end
                default: w_ctl = CTL_ALL_EN;
            endcase
        end
    end

    assign w_wait_inc = r_wait + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // Counting restarts whenever a wait state is left, even into another wait.
            if (is_wait(r_state) && (w_state_nxt == r_state)) begin
                if (r_wait != WAIT_MAX)     r_wait <= w_wait_inc;
                if (w_wait_inc == WAIT_MAX) r_err  <= 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (((r_state != ST_RUN) || w_load_use) && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_en        = w_ctl[CTL_PC_EN];
    assign bus.ifid_en      = w_ctl[CTL_IFID_EN];
    assign bus.idex_en      = w_ctl[CTL_IDEX_EN];
    assign bus.exmem_en     = w_ctl[CTL_EXMEM_EN];
    assign bus.memwb_en     = w_ctl[CTL_MEMWB_EN];
    assign bus.ifid_bubble  = w_ctl[CTL_IFID_BUB];
    assign bus.idex_bubble  = w_ctl[CTL_IDEX_BUB];
    assign bus.memwb_bubble = w_ctl[CTL_MEMWB_BUB];
    assign bus.state        = r_state;
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.err_timeout  = r_err;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a per-cycle vector table plus
// hand-written sequences for stall counting, timeout and reset.
module tb_pipe_stall_ctrl;

    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_IS   = 5'b10000;
    localparam logic [4:0] E_ID   = 5'b01000;
    localparam logic [4:0] E_DS   = 5'b00100;
    localparam logic [4:0] E_DD   = 5'b00010;
    localparam logic [4:0] E_BR   = 5'b00001;

    // Expected control bundle {pc,ifid,idex,exmem,memwb en, ifid,idex,memwb bubble}
    localparam logic [7:0] X_RUN  = 8'hF8;
    localparam logic [7:0] X_FRZ  = 8'h09;
    localparam logic [7:0] X_BR   = 8'hFE;
    localparam logic [7:0] X_LU   = 8'h3A;
    localparam logic [7:0] X_IFS  = 8'h7C;
    localparam logic [7:0] X_FL   = 8'hFC;
    localparam logic [7:0] X_RST  = 8'h7F;

    typedef struct {
        string      name;
        logic [4:0] ev;
        int         hz;
        logic [7:0] ctl;
        logic [2:0] st;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t tbl[39];

    pipe_stall_ctrl_if #(.CNT_W(16)) bus();

    pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [4:0] ev, int hz, logic [7:0] ctl, logic [2:0] st);
        vec_t v;
        v.name = nm; v.ev = ev; v.hz = hz; v.ctl = ctl; v.st = st;
        return v;
    endfunction

    function automatic logic [7:0] ctl_now();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_bubble, bus.idex_bubble, bus.memwb_bubble};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // hz: 0 none, 1 load-use via rs, 2 load-use via rt, 3 no-regwrite,
    // 4 no source reads, 5 load-use on register 0
    task automatic drive(input logic [4:0] ev, input int hz);
        {bus.imem_stall, bus.imem_done, bus.dmem_stall, bus.dmem_done, bus.branch_taken} = ev;
        bus.id_rs = 3'd1; bus.id_rt = 3'd2; bus.id_reads_rs = 1'b0; bus.id_reads_rt = 1'b0;
        bus.idex_wreg = 3'd7; bus.idex_regwrite = 1'b0; bus.idex_memtoreg = 1'b0;
        case (hz)
            1: begin bus.idex_wreg = 3'd3; bus.id_rs = 3'd3; bus.id_reads_rs = 1'b1;
                     bus.idex_regwrite = 1'b1; bus.idex_memtoreg = 1'b1; end
            2: begin bus.idex_wreg = 3'd5; bus.id_rs = 3'd5; bus.id_rt = 3'd5; bus.id_reads_rt = 1'b1;
                     bus.idex_regwrite = 1'b1; bus.idex_memtoreg = 1'b1; end
            3: begin bus.idex_wreg = 3'd3; bus.id_rs = 3'd3; bus.id_reads_rs = 1'b1;
                     bus.idex_regwrite = 1'b0; bus.idex_memtoreg = 1'b1; end
            4: begin bus.idex_wreg = 3'd3; bus.id_rs = 3'd3; bus.id_rt = 3'd3;
                     bus.idex_regwrite = 1'b1; bus.idex_memtoreg = 1'b1; end
            5: begin bus.idex_wreg = 3'd0; bus.id_rs = 3'd0; bus.id_reads_rs = 1'b1;
                     bus.idex_regwrite = 1'b1; bus.idex_memtoreg = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(E_NONE, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        drive(E_NONE, 0);

        tbl[0]  = mk("idle0",       E_NONE,      0, X_RUN, 3'd0);
        tbl[1]  = mk("idle1",       E_NONE,      0, X_RUN, 3'd0);
        tbl[2]  = mk("lu_rs",       E_NONE,      1, X_LU,  3'd0);
        tbl[3]  = mk("lu_state",    E_NONE,      0, X_RUN, 3'd1);
        tbl[4]  = mk("lu_back",     E_NONE,      0, X_RUN, 3'd0);
        tbl[5]  = mk("lu_rt",       E_NONE,      2, X_LU,  3'd0);
        tbl[6]  = mk("lu_held",     E_NONE,      2, X_RUN, 3'd1);
        tbl[7]  = mk("no_regwr",    E_NONE,      3, X_RUN, 3'd0);
        tbl[8]  = mk("no_reads",    E_NONE,      4, X_RUN, 3'd0);
        tbl[9]  = mk("lu_r0",       E_NONE,      5, X_LU,  3'd0);
        tbl[10] = mk("lu_r0_st",    E_NONE,      0, X_RUN, 3'd1);
        tbl[11] = mk("dm_enter",    E_DS,        0, X_FRZ, 3'd0);
        tbl[12] = mk("dm_wait",     E_DS,        0, X_FRZ, 3'd2);
        tbl[13] = mk("dm_ign_br",   E_DS | E_BR, 0, X_FRZ, 3'd2);
        tbl[14] = mk("dm_done",     E_DD,        0, X_RUN, 3'd2);
        tbl[15] = mk("dm_back",     E_NONE,      0, X_RUN, 3'd0);
        tbl[16] = mk("br_run",      E_BR,        0, X_BR,  3'd0);
        tbl[17] = mk("br_flush",    E_NONE,      0, X_FL,  3'd4);
        tbl[18] = mk("br_back",     E_NONE,      0, X_RUN, 3'd0);
        tbl[19] = mk("im_enter",    E_IS,        0, X_IFS, 3'd0);
        tbl[20] = mk("im_wait",     E_IS,        0, X_IFS, 3'd3);
        tbl[21] = mk("im_br1",      E_IS | E_BR, 0, X_FRZ, 3'd3);
        tbl[22] = mk("im_br2",      E_BR,        0, X_FRZ, 3'd3);
        tbl[23] = mk("im_br3",      E_BR,        0, X_FRZ, 3'd3);
        tbl[24] = mk("im_done_br",  E_ID | E_BR, 0, X_BR,  3'd3);
        tbl[25] = mk("im_flush",    E_NONE,      0, X_FL,  3'd4);
        tbl[26] = mk("im_back",     E_NONE,      0, X_RUN, 3'd0);
        tbl[27] = mk("prio_dm",     E_IS | E_DS | E_BR, 1, X_FRZ, 3'd0);
        tbl[28] = mk("prio_dmdone", E_DD,        0, X_RUN, 3'd2);
        tbl[29] = mk("prio_br",     E_IS | E_BR, 1, X_BR,  3'd0);
        tbl[30] = mk("prio_flush",  E_NONE,      0, X_FL,  3'd4);
        tbl[31] = mk("prio_lu",     E_IS,        1, X_LU,  3'd0);
        tbl[32] = mk("lu_then_im",  E_IS,        0, X_IFS, 3'd1);
        tbl[33] = mk("im_done",     E_ID,        0, X_RUN, 3'd3);
        tbl[34] = mk("im_done_bk",  E_NONE,      0, X_RUN, 3'd0);
        tbl[35] = mk("im2_enter",   E_IS,        0, X_IFS, 3'd0);
        tbl[36] = mk("im_to_dm",    E_DS,        0, X_FRZ, 3'd3);
        tbl[37] = mk("im_dm_done",  E_DD,        0, X_RUN, 3'd2);
        tbl[38] = mk("im_dm_back",  E_NONE,      0, X_RUN, 3'd0);

        // Reset held for two edges, then released with no events
        #1;
        chk("rst_ctl0", 32'(ctl_now()), 32'(X_RST));
        tick();
        chk("rst_ctl1", 32'(ctl_now()), 32'(X_RST));
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ctl", 32'(ctl_now()), 32'(X_RUN));
        tick();
        chk("rel_state", 32'(bus.state), 32'd0);
        chk("rel_stall", 32'(bus.stall_cycles), 32'd0);

        for (int i = 0; i < 39; i++) begin
            drive(tbl[i].ev, tbl[i].hz);
            #1;
            chk({tbl[i].name, "_ctl"}, 32'(ctl_now()), 32'(tbl[i].ctl));
            chk({tbl[i].name, "_st"}, 32'(bus.state), 32'(tbl[i].st));
            tick();
        end

        // Stall counter: one load-use, then a 5-cycle data-memory stall
        do_reset();
        drive(E_NONE, 1);
        #1;
        chk("cnt_lu0", 32'(bus.stall_cycles), 32'd0);
        tick();
        drive(E_NONE, 0);
        chk("cnt_lu_st", 32'(bus.state), 32'd1);
        chk("cnt_lu1", 32'(bus.stall_cycles), 32'd1);
        tick();
        chk("cnt_lu_back", 32'(bus.state), 32'd0);
        chk("cnt_lu2", 32'(bus.stall_cycles), 32'd2);
        for (int k = 0; k < 5; k++) begin
            drive(E_DS, 0);
            #1;
            chk("cnt_dm_frz", 32'(ctl_now()), 32'(X_FRZ));
            tick();
        end
        drive(E_DD, 0);
        #1;
        chk("cnt_dm_done", 32'(ctl_now()), 32'(X_RUN));
        tick();
        drive(E_NONE, 0);
        chk("cnt_dm_st", 32'(bus.state), 32'd0);
        chk("cnt_dm_total", 32'(bus.stall_cycles), 32'd7);

        // Timeout after four wait cycles, sticky until reset
        do_reset();
        chk("to_err0", 32'(bus.err_timeout), 32'd0);
        drive(E_DS, 0);
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("to_err_c%0d", k), 32'(bus.err_timeout), (k >= 6) ? 32'd1 : 32'd0);
            tick();
        end
        drive(E_DD, 0);
        #1;
        chk("to_done_err", 32'(bus.err_timeout), 32'd1);
        tick();
        drive(E_NONE, 0);
        chk("to_back_st", 32'(bus.state), 32'd0);
        chk("to_back_err", 32'(bus.err_timeout), 32'd1);
        tick();
        chk("to_sticky", 32'(bus.err_timeout), 32'd1);

        // Reset landing in the middle of a wait
        drive(E_DS, 0);
        tick();
        chk("mid_wait_st", 32'(bus.state), 32'd2);
        drive(E_NONE, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'(ctl_now()), 32'(X_RST));
        tick();
        chk("mid_rst_st", 32'(bus.state), 32'd0);
        chk("mid_rst_err", 32'(bus.err_timeout), 32'd0);
        chk("mid_rst_cnt", 32'(bus.stall_cycles), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rel_st", 32'(bus.state), 32'd0);
        chk("mid_rel_ctl", 32'(ctl_now()), 32'(X_RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
